// File: rtl/nvm_pkg.sv
// Shared types for the NVM reader/writer pair: FSM states and the control strobe bundle.
package nvm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        PROG  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic load;
        logic shift;
        logic prog;
        logic done;
    } nvm_ctrl_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nvm_piso.sv
// Parallel-in / serial-out shifter. The serial output is its own flop, so the
// frame MSB appears the cycle after the first shift edge and sdo idles at 0.
module nvm_piso #(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         sdo
);

    logic [N-1:0] sr;

    // Capture the frame on load; on each shift edge present the MSB and move up.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            sdo <= 1'b0;
        end else begin
            if (load)
                sr <= din;
            else if (shift)
                sr <= sr << 1;
            sdo <= shift ? sr[N-1] : 1'b0;
        end
    end

endmodule

// File: rtl/nvm_writer.sv
// NVM write sequencer: accepts one {addr, data} frame, shifts it out MSB-first,
// then holds the program pulse for PROG_CYCLES cycles. All outputs are flops.
module nvm_writer
    import nvm_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int PROG_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              nvm_load,
    output logic              nvm_shift,
    output logic              nvm_sdo,
    output logic              nvm_prog
);

    localparam int N     = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(imax(N, PROG_CYCLES) + 1);

    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    nvm_ctrl_t  ctrl_q, ctrl_d;
    logic       busy_q, busy_d;
    logic       capture;

    // Next state, shared counter reload/decrement, and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_en) begin
                    state_d = LOAD;
                    capture = 1'b1;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(N - 1);
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = PROG;
                    cnt_d   = CNT_W'(PROG_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PROG: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Accepting here gives back-to-back writes with no idle cycle.
                cnt_d = '0;
                if (wr_en) begin
                    state_d = LOAD;
                    capture = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ctrl_d.load  = (state_d == LOAD);
        ctrl_d.shift = (state_d == SHIFT);
        ctrl_d.prog  = (state_d == PROG);
        ctrl_d.done  = (state_d == DONE);
        busy_d       = (state_d == LOAD) || (state_d == SHIFT) || (state_d == PROG);
    end

    // State, counter and output registers; reset aborts any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
        end
    end

    nvm_piso #(.N(N)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .shift (state_d == SHIFT),
        .din   ({wr_addr, wr_data}),
        .sdo   (nvm_sdo)
    );

    assign busy      = busy_q;
    assign done      = ctrl_q.done;
    assign nvm_load  = ctrl_q.load;
    assign nvm_shift = ctrl_q.shift;
    assign nvm_prog  = ctrl_q.prog;

endmodule

// File: tb/tb_nvm_writer.sv
// Directed bench for nvm_writer: two instances (PROG_CYCLES 16 and 1) share stimulus.
module tb_nvm_writer;

    localparam int N = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic busy0, done0, load0, shift0, sdo0, prog0;
    logic busy1, done1, load1, shift1, sdo1, prog1;

    int  vectors = 0;
    int  errs = 0;
    bit  started = 1'b0;

    wire [5:0] obs0 = {busy0, done0, load0, shift0, sdo0, prog0};
    wire [5:0] obs1 = {busy1, done1, load1, shift1, sdo1, prog1};

    always #5 clk = ~clk;

    nvm_writer #(.DATA_W(8), .ADDR_W(4), .PROG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy0), .done(done0), .nvm_load(load0), .nvm_shift(shift0),
        .nvm_sdo(sdo0), .nvm_prog(prog0)
    );

    nvm_writer #(.DATA_W(8), .ADDR_W(4), .PROG_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy1), .done(done1), .nvm_load(load1), .nvm_shift(shift1),
        .nvm_sdo(sdo1), .nvm_prog(prog1)
    );

    // Expected {busy,done,load,shift,sdo,prog} in cycle c after the accepting edge (c=1 is LOAD).
    function automatic logic [5:0] exp_out(input int c, input logic [11:0] f, input int p);
        logic b, d, l, s, o, g;
        b = (c >= 1) && (c <= N + p + 1);
        l = (c == 1);
        s = (c >= 2) && (c <= N + 1);
        o = 1'b0;
        if (s) o = f[N + 1 - c];
        g = (c >= N + 2) && (c <= N + p + 1);
        d = (c == N + p + 2);
        return {b, d, l, s, o, g};
    endfunction

    // Strobes must be one-hot-or-zero every cycle, on both instances.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if ($countones({load0, shift0, prog0, done0}) > 1 ||
                $countones({load1, shift1, prog1, done1}) > 1) begin
                errs++;
                $display("FAIL onehot t=%0t got %b / %b want at most one strobe",
                         $time, {load0, shift0, prog0, done0}, {load1, shift1, prog1, done1});
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        vectors++;
        if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
            errs++;
            $display("FAIL reset got %b / %b want 000000", obs0, obs1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (obs0 !== 6'b0) begin
            errs++;
            $display("FAIL idle got %b want 000000", obs0);
        end
    endtask

    task automatic test_single();
        logic [11:0] seq = '0;
        wr_en = 1'b1; wr_addr = 4'hA; wr_data = 8'h5C;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_en = 1'b0;
            if (shift0) seq = {seq[10:0], sdo0};
            vectors++;
            if (obs0 !== exp_out(c, 12'hA5C, 16)) begin
                errs++;
                $display("FAIL single c=%0d got %b want %b", c, obs0, exp_out(c, 12'hA5C, 16));
            end
        end
        vectors++;
        if (seq !== 12'b1010_0101_1100) begin
            errs++;
            $display("FAIL single_sdo got %b want 101001011100", seq);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        wr_en = 1'b1; wr_addr = 4'h5; wr_data = 8'h12;
        for (int c = 1; c <= 61; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin wr_addr = 4'h3; wr_data = 8'hFF; end
            if (c == 31) wr_en = 1'b0;
            e = (c <= 30) ? exp_out(c, 12'h512, 16) : exp_out(c - 30, 12'h3FF, 16);
            vectors++;
            if (obs0 !== e) begin
                errs++;
                $display("FAIL b2b c=%0d got %b want %b", c, obs0, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int dones = 0;
        wr_en = 1'b1; wr_addr = 4'h1; wr_data = 8'hA7;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 1 || c == 6 || c == 21) wr_en = 1'b0;
            if (c == 5 || c == 20) begin wr_en = 1'b1; wr_addr = 4'hF; wr_data = 8'h00; end
            if (done0) dones++;
            vectors++;
            if (obs0 !== exp_out(c, 12'h1A7, 16)) begin
                errs++;
                $display("FAIL ignore c=%0d got %b want %b", c, obs0, exp_out(c, 12'h1A7, 16));
            end
        end
        vectors++;
        if (dones != 1) begin
            errs++;
            $display("FAIL ignore_dones got %0d want 1", dones);
        end
    endtask

    task automatic test_abort();
        int stop_at;
        for (int k = 0; k < 2; k++) begin
            stop_at = (k == 0) ? 6 : 21;  // 5th shift bit, then 8th prog cycle
            wr_en = 1'b1; wr_addr = 4'h2; wr_data = 8'hB4;
            for (int c = 1; c <= stop_at; c++) begin
                @(posedge clk); #1;
                if (c == 1) wr_en = 1'b0;
                vectors++;
                if (obs0 !== exp_out(c, 12'h2B4, 16)) begin
                    errs++;
                    $display("FAIL abort%0d c=%0d got %b want %b", k, c, obs0, exp_out(c, 12'h2B4, 16));
                end
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            vectors++;
            if (obs0 !== 6'b0 || obs1 !== 6'b0) begin
                errs++;
                $display("FAIL abort%0d_rst got %b / %b want 000000", k, obs0, obs1);
            end
            for (int c = 0; c < 35; c++) begin
                @(posedge clk); #1;
                vectors++;
                if (obs0 !== 6'b0) begin
                    errs++;
                    $display("FAIL abort%0d_quiet c=%0d got %b want 000000", k, c, obs0);
                end
            end
        end
        wr_en = 1'b1; wr_addr = 4'h1; wr_data = 8'h81;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_en = 1'b0;
            vectors++;
            if (obs0 !== exp_out(c, 12'h181, 16)) begin
                errs++;
                $display("FAIL fresh c=%0d got %b want %b", c, obs0, exp_out(c, 12'h181, 16));
            end
        end
    endtask

    task automatic test_lsb_only();
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 8'h01;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_en = 1'b0;
            vectors++;
            if (obs0 !== exp_out(c, 12'h001, 16)) begin
                errs++;
                $display("FAIL lsb c=%0d got %b want %b", c, obs0, exp_out(c, 12'h001, 16));
            end
        end
    endtask

    task automatic test_short_prog();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 4'hA; wr_data = 8'h5C;
        for (int c = 1; c <= 31; c++) begin
            @(posedge clk); #1;
            if (c == 1) wr_en = 1'b0;
            vectors++;
            if (obs1 !== exp_out(c, 12'hA5C, 1)) begin
                errs++;
                $display("FAIL prog1 c=%0d got %b want %b", c, obs1, exp_out(c, 12'hA5C, 1));
            end
            vectors++;
            if (obs0 !== exp_out(c, 12'hA5C, 16)) begin
                errs++;
                $display("FAIL prog16 c=%0d got %b want %b", c, obs0, exp_out(c, 12'hA5C, 16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        test_lsb_only();
        test_short_prog();
        @(posedge clk); #1;
        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
